pc_fetch_unit: RTL and testbench

- Consumer side of the sequential-PC path.
- Owns the architectural PC register and issues instruction fetches to instruction memory, one outstanding request at a time.
- Buffers returned words, with their PCs, in a small queue toward decode.
- Redirects from branch/jump resolution and flushes stale fetches.

---
 rtl/pc_fetch_unit.sv | 161 ++++++++++++++++
 tb/tb_pc_fetch_unit.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// Instruction fetch front end: owns the architectural PC, issues one outstanding
// fetch at a time and buffers returned words with their PCs toward decode.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned QUEUE_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
);

  localparam int unsigned PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DROP = 2'd3
  } state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } entry_t;

  state_t           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      req_pc_q, req_pc_d;
  entry_t           mem_q [QUEUE_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             fire;
  logic             push;
  logic             pop;
  logic [31:0]      redirect_tgt;
  entry_t           push_entry;
  entry_t           head_d;
  logic             unused_bits;

  assign redirect_tgt = {redirect_pc[31:2], 2'b00};
  assign unused_bits  = ^redirect_pc[1:0];

  // imem_req is only ever high in REQ, so it doubles as the handshake qualifier
  assign fire = (state_q == REQ) && imem_req && imem_gnt;
  assign pop  = inst_valid && inst_ready;
  assign push = (state_q == WAIT) && imem_rvalid && !redirect_valid;

  assign push_entry.pc   = req_pc_q;
  assign push_entry.data = imem_rdata;

  // Fetch sequencing and PC update; redirect overrides both
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;

    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (fire) begin
          req_pc_d = pc_q;
          pc_d     = pc_q + 32'd4;
          state_d  = WAIT;
        end
      end
      WAIT: if (imem_rvalid) state_d = REQ;
      DROP: if (imem_rvalid) state_d = REQ;
      default: state_d = IDLE;
    endcase

    if (redirect_valid) begin
      pc_d = redirect_tgt;
      case (state_q)
        IDLE:    state_d = REQ;
        REQ:     state_d = fire ? DROP : REQ;
        WAIT:    state_d = imem_rvalid ? REQ : DROP;
        DROP:    state_d = imem_rvalid ? REQ : DROP;
        default: state_d = IDLE;
      endcase
    end
  end

  // Queue pointers/count and the entry that will sit at the head next cycle
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;

    if (redirect_valid) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    head_d = mem_q[rd_ptr_d];
    // Entry being written this cycle becomes the head when the queue drains to it
    if (push && (count_q == CNT_W'(pop))) head_d = push_entry;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      req_pc_q <= RESET_PC;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < QUEUE_DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= push_entry;
    end
  end

  // Registered outputs computed from next-state values, so nothing from inst_ready reaches imem_req combinationally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      imem_req   <= 1'b0;
      imem_addr  <= RESET_PC;
      inst_valid <= 1'b0;
      inst_data  <= '0;
      inst_pc    <= '0;
    end else begin
      imem_req   <= (state_d == REQ) && (count_d < CNT_W'(QUEUE_DEPTH));
      imem_addr  <= pc_d;
      inst_valid <= (count_d != '0);
      if (count_d != '0) begin
        inst_data <= head_d.data;
        inst_pc   <= head_d.pc;
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: transaction-level model plus directed scenarios
// covering streaming, back-pressure, redirects, PC wrap and async reset.
module tb_pc_fetch_unit;

  localparam int          DEPTH = 2;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_ready = 1'b0;

  int n_chk  = 0;
  int n_fail = 0;

  // model state
  ent_t        m_q[$];
  logic [31:0] m_issued[$];
  logic [31:0] m_deliv[$];
  logic [31:0] m_pc = RPC;
  logic [31:0] m_req_pc = RPC;
  bit          m_started = 0;
  bit          m_out = 0;
  bit          m_drop = 0;
  bit          mf_fire, mf_rv, mf_pop, mf_req;
  ent_t        m_e;

  // memory responder state
  int          cyc = 0;
  int          lat = 1;
  bit          resp_pend = 0;
  int          resp_cycle = 0;
  logic [31:0] resp_addr = 32'h0;

  pc_fetch_unit #(.RESET_PC(RPC), .QUEUE_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst_data(inst_data), .inst_pc(inst_pc),
    .inst_ready(inst_ready)
  );

  initial forever #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  function automatic bit exp_req();
    return m_started && !m_out && (m_q.size() < DEPTH);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic pin(input string name, input logic [31:0] q[$], input int idx, input logic [31:0] exp);
    n_chk++;
    if (idx >= q.size()) begin
      n_fail++;
      $display("FAIL %s: got only %0d entries, expected entry %0d = %h", name, q.size(), idx, exp);
    end else if (q[idx] !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, q[idx], exp);
    end
  endtask

  task automatic found(input string name, input bit ok);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got timeout expected event", name);
    end
  endtask

  // Behavioural model: fetch bookkeeping in terms of outstanding/dropped requests and a plain queue
  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_q.delete(); m_issued.delete(); m_deliv.delete();
      m_pc = RPC; m_started = 0; m_out = 0; m_drop = 0; resp_pend = 0;
    end else begin
      mf_req  = exp_req();
      mf_fire = mf_req && imem_gnt;
      mf_rv   = m_out && imem_rvalid;
      mf_pop  = (m_q.size() > 0) && inst_ready;
      cyc++;
      if (imem_rvalid) resp_pend = 0;
      if (mf_fire) begin
        resp_pend  = 1;
        resp_cycle = cyc - 1 + lat;
        resp_addr  = m_pc;
        m_issued.push_back(m_pc);
      end
      if (mf_pop) m_deliv.push_back(m_q[0].pc);
      if (redirect_valid) begin
        m_q.delete();
        if (mf_fire) begin m_out = 1; m_drop = 1; end
        else if (mf_rv) begin m_out = 0; m_drop = 0; end
        else if (m_out) m_drop = 1;
        m_pc = {redirect_pc[31:2], 2'b00};
      end else begin
        if (mf_pop) void'(m_q.pop_front());
        if (mf_rv) begin
          if (!m_drop) begin
            m_e.pc = m_req_pc; m_e.data = imem_rdata;
            m_q.push_back(m_e);
          end
          m_out = 0; m_drop = 0;
        end
        if (mf_fire) begin m_out = 1; m_req_pc = m_pc; m_pc = m_pc + 32'd4; end
      end
      m_started = 1;
    end
  end

  // Per-cycle comparison of every output against the model
  initial forever begin
    @(negedge clk);
    if (rst) begin
      chk("rst_imem_req", 32'(imem_req), 32'd0);
      chk("rst_imem_addr", imem_addr, RPC);
      chk("rst_inst_valid", 32'(inst_valid), 32'd0);
      chk("rst_inst_data", inst_data, 32'd0);
      chk("rst_inst_pc", inst_pc, 32'd0);
    end else begin
      chk("imem_req", 32'(imem_req), 32'(exp_req()));
      chk("imem_addr", imem_addr, m_pc);
      chk("inst_valid", 32'(inst_valid), 32'(m_q.size() > 0));
      if (m_q.size() > 0) begin
        chk("inst_pc", inst_pc, m_q[0].pc);
        chk("inst_data", inst_data, m_q[0].data);
      end
    end
  end

  task automatic cycle();
    @(negedge clk); #1;
    redirect_valid = 1'b0;
    imem_rvalid = resp_pend && (cyc >= resp_cycle) && !rst;
    imem_rdata  = imem_rvalid ? word(resp_addr) : 32'h0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    imem_gnt = 1'b0; inst_ready = 1'b0;
    run(2);
    rst = 1'b0;
  endtask

  task automatic redirect(input logic [31:0] tgt);
    redirect_valid = 1'b1;
    redirect_pc    = tgt;
  endtask

  initial begin
    bit ok;
    #1;
    // streaming, 1-cycle memory, always-ready decode
    lat = 1;
    apply_reset();
    imem_gnt = 1'b1; inst_ready = 1'b1;
    run(14);
    pin("s1_issue0", m_issued, 0, 32'd0);
    pin("s1_issue1", m_issued, 1, 32'd4);
    pin("s1_issue2", m_issued, 2, 32'd8);
    pin("s1_issue3", m_issued, 3, 32'd12);
    pin("s1_deliv0", m_deliv, 0, 32'd0);
    pin("s1_deliv2", m_deliv, 2, 32'd8);

    // back-pressure: full queue holds the request
    apply_reset();
    imem_gnt = 1'b1; inst_ready = 1'b0;
    run(10);
    chk("bp_req_held", 32'(imem_req), 32'd0);
    chk("bp_addr", imem_addr, 32'd8);
    chk("bp_valid", 32'(inst_valid), 32'd1);
    chk("bp_head_pc", inst_pc, 32'd0);
    chk("bp_head_data", inst_data, 32'hC0DE_0000);
    inst_ready = 1'b1;
    run(8);
    pin("bp_deliv0", m_deliv, 0, 32'd0);
    pin("bp_deliv1", m_deliv, 1, 32'd4);
    pin("bp_issue2", m_issued, 2, 32'd8);

    // redirect while waiting for the response to pc 4
    lat = 3;
    apply_reset();
    imem_gnt = 1'b1; inst_ready = 1'b1;
    ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      cycle();
      ok = resp_pend && (resp_addr == 32'd4) && (cyc < resp_cycle);
    end
    found("s3_wait_at_4", ok);
    redirect(32'h100);
    run(16);
    pin("s3_issue2", m_issued, 2, 32'h100);
    pin("s3_deliv0", m_deliv, 0, 32'd0);
    pin("s3_deliv1", m_deliv, 1, 32'h100);

    // redirect in the same cycle as rvalid
    lat = 2;
    apply_reset();
    imem_gnt = 1'b1; inst_ready = 1'b1;
    ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      cycle();
      ok = imem_rvalid && (resp_addr == 32'd4);
    end
    found("s4a_rvalid_4", ok);
    redirect(32'h200);
    run(12);
    pin("s4a_issue2", m_issued, 2, 32'h200);
    pin("s4a_deliv1", m_deliv, 1, 32'h200);

    // redirect in the same cycle as the grant
    apply_reset();
    imem_gnt = 1'b1; inst_ready = 1'b1;
    ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      cycle();
      ok = exp_req() && (m_pc == 32'd4);
    end
    found("s4b_req_4", ok);
    redirect(32'h300);
    cycle();
    chk("s4b_drop_req", 32'(imem_req), 32'd0);
    chk("s4b_drop_addr", imem_addr, 32'h300);
    run(12);
    pin("s4b_issue1", m_issued, 1, 32'd4);
    pin("s4b_issue2", m_issued, 2, 32'h300);
    pin("s4b_deliv1", m_deliv, 1, 32'h300);

    // alignment and wrap-around
    lat = 1;
    apply_reset();
    imem_gnt = 1'b0; inst_ready = 1'b1;
    cycle();
    redirect(32'hFFFF_FFFE);
    cycle();
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    chk("wrap_req", 32'(imem_req), 32'd1);
    imem_gnt = 1'b1;
    run(10);
    pin("wrap_issue0", m_issued, 0, 32'hFFFF_FFFC);
    pin("wrap_issue1", m_issued, 1, 32'h0000_0000);
    pin("wrap_deliv0", m_deliv, 0, 32'hFFFF_FFFC);

    // async reset while a fetch is outstanding and the queue is occupied
    lat = 3;
    apply_reset();
    imem_gnt = 1'b1; inst_ready = 1'b0;
    ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      cycle();
      ok = resp_pend && (m_q.size() > 0);
    end
    found("s6_wait_nonempty", ok);
    #2 rst = 1'b1;
    #1;
    chk("arst_req", 32'(imem_req), 32'd0);
    chk("arst_valid", 32'(inst_valid), 32'd0);
    run(2);
    rst = 1'b0;
    cycle();
    chk("arst_first_req", 32'(imem_req), 32'd1);
    chk("arst_first_addr", imem_addr, RPC);
    run(8);
    pin("arst_issue0", m_issued, 0, RPC);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test expected completion");
    $fatal(1, "watchdog");
  end

endmodule
